// File: rtl/pulse_seg_unit_if.sv
// Signal bundle for pulse_seg_unit: edge-pulse level/pulse pair and 7-segment decode pair.
interface pulse_seg_unit_if;
  logic       d;
  logic       q;
  logic [3:0] decode;
  logic [6:0] decoded;

  modport master (output d, output decode, input q, input decoded);
  modport slave  (input d, input decode, output q, output decoded);
endinterface

// File: rtl/pulse_seg_unit.sv
// Edge-to-pulse converter plus active-low 7-segment digit decoder.
// Define PULSE_SEG_HEX_EN to show A-F for decode values 10-15 instead of blanking.
module pulse_seg_unit #(
  parameter bit RISING = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  pulse_seg_unit_if.slave  bus
);

  // Reset loads the pre-edge level so a d already in its post-edge state pulses after release.
  localparam logic RST_LVL = ~RISING;

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = bus.d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_LVL;
      s2_q <= RST_LVL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_comb begin
    if (RISING) bus.q = s1_q & ~s2_q;
    else        bus.q = s2_q & ~s1_q;
  end

  // Segment order [6:0] = g,f,e,d,c,b,a; a 0 bit lights the segment.
  always_comb begin
    bus.decoded = 7'h7F;
    case (bus.decode)
      4'd0:    bus.decoded = 7'h40;
      4'd1:    bus.decoded = 7'h79;
      4'd2:    bus.decoded = 7'h24;
      4'd3:    bus.decoded = 7'h30;
      4'd4:    bus.decoded = 7'h19;
      4'd5:    bus.decoded = 7'h12;
      4'd6:    bus.decoded = 7'h02;
      4'd7:    bus.decoded = 7'h78;
      4'd8:    bus.decoded = 7'h00;
      4'd9:    bus.decoded = 7'h10;
`ifdef PULSE_SEG_HEX_EN
      4'd10:   bus.decoded = 7'h08;
      4'd11:   bus.decoded = 7'h03;
      4'd12:   bus.decoded = 7'h46;
      4'd13:   bus.decoded = 7'h21;
      4'd14:   bus.decoded = 7'h06;
      4'd15:   bus.decoded = 7'h0E;
`else
      default: bus.decoded = 7'h7F;
`endif
    endcase
  end

endmodule

// File: tb/tb_pulse_seg_unit.sv
// Directed bench for pulse_seg_unit: one rising-edge and one falling-edge instance.
module tb_pulse_seg_unit;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses;

  pulse_seg_unit_if rise_if ();
  pulse_seg_unit_if fall_if ();

  pulse_seg_unit #(.RISING(1'b1)) u_rise (.clk(clk), .rst(rst), .bus(rise_if.slave));
  pulse_seg_unit #(.RISING(1'b0)) u_fall (.clk(clk), .rst(rst), .bus(fall_if.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked on the falling edge, well away from posedge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  logic [6:0] seg_exp [16];

  initial begin
    seg_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef PULSE_SEG_HEX_EN
                7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif

    rst = 1'b1;
    rise_if.d = 1'b0;
    fall_if.d = 1'b1;
    rise_if.decode = 4'd0;
    fall_if.decode = 4'd0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("rst_q_rise", {7'd0, rise_if.q}, 8'd0);
      checkOutput("rst_q_fall", {7'd0, fall_if.q}, 8'd0);
    end
    checkOutput("rst_s_rise", {6'd0, u_rise.s1_q, u_rise.s2_q}, 8'b00);
    checkOutput("rst_s_fall", {6'd0, u_fall.s1_q, u_fall.s2_q}, 8'b11);
    rise_if.decode = 4'd5;
    #1 checkOutput("rst_decoded", {1'b0, rise_if.decoded}, 8'h12);

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("post_rst_q_rise", {7'd0, rise_if.q}, 8'd0);
      checkOutput("post_rst_q_fall", {7'd0, fall_if.q}, 8'd0);
    end

    // Rising edge held ten cycles: exactly one pulse in the first cycle
    rise_if.d = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("rise_hold_%0d", i), {7'd0, rise_if.q}, (i == 0) ? 8'd1 : 8'd0);
      pulses += int'(rise_if.q);
    end
    checkOutput("rise_hold_count", 8'(pulses), 8'd1);
    rise_if.d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("rise_fall_edge", {7'd0, rise_if.q}, 8'd0);
    end

    // Falling instance: 1->0 pulses once, 0->1 does not
    fall_if.d = 1'b0;
    applyStimulus(1);
    checkOutput("fall_pulse", {7'd0, fall_if.q}, 8'd1);
    applyStimulus(1);
    checkOutput("fall_pulse_end", {7'd0, fall_if.q}, 8'd0);
    fall_if.d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("fall_rise_edge", {7'd0, fall_if.q}, 8'd0);
    end

    // Glitch between clock edges is never sampled
    #1 rise_if.d = 1'b1;
    #2 rise_if.d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("glitch", {7'd0, rise_if.q}, 8'd0);
    end

    // Toggle every cycle: pulse on every second cycle
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rise_if.d = ~rise_if.d;
      applyStimulus(1);
      checkOutput($sformatf("toggle_%0d", i), {7'd0, rise_if.q}, (i % 2 == 0) ? 8'd1 : 8'd0);
      pulses += int'(rise_if.q);
    end
    checkOutput("toggle_count", 8'(pulses), 8'd4);
    rise_if.d = 1'b0;
    applyStimulus(2);

    // Reset asserted while q is high clears it at the next edge
    rise_if.d = 1'b1;
    applyStimulus(1);
    checkOutput("pre_rst_pulse", {7'd0, rise_if.q}, 8'd1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_kills_pulse", {7'd0, rise_if.q}, 8'd0);

    // d already high through reset: one pulse right after release
    applyStimulus(1);
    checkOutput("rst_hold_high", {7'd0, rise_if.q}, 8'd0);
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("release_pulse", {7'd0, rise_if.q}, 8'd1);
    applyStimulus(1);
    checkOutput("release_pulse_end", {7'd0, rise_if.q}, 8'd0);

    // Decoder sweep on both instances
    for (int v = 0; v < 16; v++) begin
      rise_if.decode = 4'(v);
      fall_if.decode = 4'(15 - v);
      #1;
      checkOutput($sformatf("seg_rise_%0d", v), {1'b0, rise_if.decoded}, {1'b0, seg_exp[v]});
      checkOutput($sformatf("seg_fall_%0d", 15 - v), {1'b0, fall_if.decoded}, {1'b0, seg_exp[15 - v]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
